// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle FETCH..WB sequencer that owns the PC
// and drives the datapath controls. Optional trap: ILLEGAL_TRAP_EN.
module multicycle_ctrl #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h0000_0028),
  parameter int unsigned     MAX_INS  = 0,
  parameter int unsigned     CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [31:0]      ins,
  input  logic             zero,
  input  logic [XLEN-1:0]  PCp4,
  input  logic [XLEN-1:0]  branch,
  input  logic [XLEN-1:0]  jTarget,
  output logic [XLEN-1:0]  PCin,
  output logic             RegWrite,
  output logic             ALUSrc,
  output logic [2:0]       op,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             Mem2Reg,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired,
  output logic             done,
  output logic             err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_TRAP   = 3'd6;

  localparam logic [6:0] OPC_LD  = 7'h03;
  localparam logic [6:0] OPC_ST  = 7'h23;
  localparam logic [6:0] OPC_R   = 7'h33;
  localparam logic [6:0] OPC_I   = 7'h13;
  localparam logic [6:0] OPC_JAL = 7'h6F;
  localparam logic [6:0] OPC_BEQ = 7'h63;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam bit               LIM_EN = (MAX_INS != 0);
  localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_INS);
  localparam logic [CNT_W-1:0] CNT_1  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

  logic [2:0]       state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [31:0]      ir_q, ir_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             done_q, done_d;
  logic             retire;
  logic             limit_hit;

  logic [6:0] opc;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       is_ld, is_st, is_r, is_i, is_jal, is_beq;
  logic       is_known;
  logic [2:0] alu_op;
  logic       unused_ir;

  assign opc      = ir_q[6:0];
  assign funct3   = ir_q[14:12];
  assign funct7_5 = ir_q[30];
  assign unused_ir = ^{ir_q[31], ir_q[29:15], ir_q[11:7]};

  assign is_ld  = (opc == OPC_LD);
  assign is_st  = (opc == OPC_ST);
  assign is_r   = (opc == OPC_R);
  assign is_i   = (opc == OPC_I);
  assign is_jal = (opc == OPC_JAL);
  assign is_beq = (opc == OPC_BEQ);
  assign is_known = is_ld | is_st | is_r | is_i | is_jal | is_beq;

  assign limit_hit = LIM_EN && ((retired_q + CNT_1) == MAX_C);

  // ALU operation selected from the latched instruction
  always_comb begin
    alu_op = ALU_ADD;
    if (is_r) begin
      unique case (funct3)
        3'b000:  alu_op = funct7_5 ? ALU_SUB : ALU_ADD;
        3'b111:  alu_op = ALU_AND;
        3'b110:  alu_op = ALU_OR;
        3'b010:  alu_op = ALU_SLT;
        default: alu_op = ALU_ADD;
      endcase
    end else if (is_beq) begin
      alu_op = ALU_SUB;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic err_q, err_d;
  logic trap_go;
`endif

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; retire marks the edge that finishes an instruction
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    trap_go = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (run && !done_q) state_d = S_FETCH;
      end
      S_FETCH: begin
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (is_known) begin
          state_d = S_EXEC;
        end else begin
`ifdef ILLEGAL_TRAP_EN
          state_d = S_TRAP;
          trap_go = 1'b1;
`else
          retire = 1'b1;
`endif
        end
      end
      S_EXEC: begin
        if (is_ld || is_st)  state_d = S_MEM;
        else if (is_beq)     retire  = 1'b1;
        else if (is_known)   state_d = S_WB;
        else                 retire  = 1'b1;
      end
      S_MEM: begin
        if (is_ld) state_d = S_WB;
        else       retire  = 1'b1;
      end
      S_WB: begin
        retire = 1'b1;
      end
      S_TRAP: begin
`ifdef ILLEGAL_TRAP_EN
        state_d = S_TRAP;
`else
        state_d = S_IDLE;
`endif
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (retire) state_d = (run && !limit_hit) ? S_FETCH : S_IDLE;
  end

  // Next values of PC, IR, retire counter and done flag
  always_comb begin
    pc_d      = pc_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    done_d    = done_q;
    if (state_q == S_FETCH) ir_d = ins;
    if (retire) begin
      if (is_beq)      pc_d = zero ? branch : PCp4;
      else if (is_jal) pc_d = jTarget;
      else             pc_d = PCp4;
      if (retired_q != CNT_SAT) retired_d = retired_q + CNT_1;
      if (limit_hit) done_d = 1'b1;
    end
  end

  // Datapath-side registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      retired_q <= '0;
      done_q    <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
      done_q    <= done_d;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  // Sticky illegal-opcode flag
  always_comb begin
    err_d = err_q | trap_go;
  end

  // Illegal-opcode flag register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Moore control outputs from state and latched instruction
  always_comb begin
    RegWrite = 1'b0;
    ALUSrc   = 1'b0;
    op       = ALU_ADD;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    Mem2Reg  = 1'b0;
    if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
      ALUSrc = is_ld | is_st | is_i | is_jal;
      op     = alu_op;
    end
    if (state_q == S_MEM) begin
      MemRead  = is_ld;
      MemWrite = is_st;
    end
    if (state_q == S_WB) begin
      MemRead  = is_ld;
      RegWrite = 1'b1;
      Mem2Reg  = is_ld;
    end
  end

  assign PCin    = pc_q;
  assign state   = state_q;
  assign retired = retired_q;
  assign done    = done_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed vector table plus hand sequences
// for reset, run handling, retire limit and illegal opcodes.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset, run, zero;
  logic [31:0] ins, branch, jTarget;
  logic [31:0] PCin, PCp4;
  logic        RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg, done, err;
  logic [2:0]  op, state;
  logic [15:0] retired;

  logic [31:0] PCin3, PCp4_3;
  logic        RegWrite3, ALUSrc3, MemRead3, MemWrite3, Mem2Reg3, done3, err3;
  logic [2:0]  op3, state3;
  logic [15:0] retired3;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  assign PCp4   = PCin + 32'd4;
  assign PCp4_3 = PCin3 + 32'd4;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .run(run), .ins(ins), .zero(zero),
    .PCp4(PCp4), .branch(branch), .jTarget(jTarget),
    .PCin(PCin), .RegWrite(RegWrite), .ALUSrc(ALUSrc), .op(op),
    .MemRead(MemRead), .MemWrite(MemWrite), .Mem2Reg(Mem2Reg),
    .state(state), .retired(retired), .done(done), .err(err)
  );

  multicycle_ctrl #(.MAX_INS(3)) dut3 (
    .clk(clk), .reset(reset), .run(run), .ins(ins), .zero(zero),
    .PCp4(PCp4_3), .branch(branch), .jTarget(jTarget),
    .PCin(PCin3), .RegWrite(RegWrite3), .ALUSrc(ALUSrc3), .op(op3),
    .MemRead(MemRead3), .MemWrite(MemWrite3), .Mem2Reg(Mem2Reg3),
    .state(state3), .retired(retired3), .done(done3), .err(err3)
  );

  typedef struct {
    string       name;
    logic [31:0] ins;
    logic        zero;
    logic [31:0] tgt;
    int          lat;
    int          rw;
    int          mr;
    int          mw;
    int          m2r;
    logic        src;
    logic [2:0]  op;
    logic        taken;
  } vec_t;

  localparam int NV = 11;
  vec_t v [NV];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] exp_pc;
    int          exp_ret;
    int          cyc, nrw, nmr, nmw, nm2r;
    logic [2:0]  op_x;
    logic        src_x;

    v[0]  = '{"add",    32'h002081B3, 1'b0, 32'h0,   4, 1, 0, 0, 0, 1'b0, 3'b010, 1'b0};
    v[1]  = '{"sub",    32'h402081B3, 1'b0, 32'h0,   4, 1, 0, 0, 0, 1'b0, 3'b110, 1'b0};
    v[2]  = '{"and",    32'h0020F1B3, 1'b0, 32'h0,   4, 1, 0, 0, 0, 1'b0, 3'b000, 1'b0};
    v[3]  = '{"or",     32'h0020E1B3, 1'b0, 32'h0,   4, 1, 0, 0, 0, 1'b0, 3'b001, 1'b0};
    v[4]  = '{"slt",    32'h0020A1B3, 1'b0, 32'h0,   4, 1, 0, 0, 0, 1'b0, 3'b111, 1'b0};
    v[5]  = '{"addi",   32'h00508193, 1'b0, 32'h0,   4, 1, 0, 0, 0, 1'b1, 3'b010, 1'b0};
    v[6]  = '{"lw",     32'h0000A183, 1'b0, 32'h0,   5, 1, 2, 0, 1, 1'b1, 3'b010, 1'b0};
    v[7]  = '{"sw",     32'h0030A023, 1'b0, 32'h0,   4, 0, 0, 1, 0, 1'b1, 3'b010, 1'b0};
    v[8]  = '{"beq_t",  32'h00208063, 1'b1, 32'h40,  3, 0, 0, 0, 0, 1'b0, 3'b110, 1'b1};
    v[9]  = '{"beq_nt", 32'h00208063, 1'b0, 32'h80,  3, 0, 0, 0, 0, 1'b0, 3'b110, 1'b0};
    v[10] = '{"jal",    32'h0000006F, 1'b0, 32'h100, 4, 1, 0, 0, 0, 1'b1, 3'b010, 1'b1};

    reset = 1'b1; run = 1'b0; ins = '0; zero = 1'b0;
    branch = '0; jTarget = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc",    PCin,     32'h28);
    chk("rst_state", state,    3'd0);
    chk("rst_ret",   retired,  0);
    chk("rst_done",  done,     0);
    chk("rst_err",   err,      0);
    chk("rst_ctl",   {RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg}, 0);
    chk("rst_op",    op,       3'b010);

    reset = 1'b0;
    run = 1'b1;
    tick();
    chk("go_fetch", state, 3'd1);

    exp_pc = 32'h28;
    exp_ret = 0;
    for (int i = 0; i < NV; i++) begin
      ins = v[i].ins;
      zero = v[i].zero;
      branch = v[i].tgt;
      jTarget = v[i].tgt;
      chk({v[i].name, "_start"}, state, 3'd1);
      cyc = 0; nrw = 0; nmr = 0; nmw = 0; nm2r = 0;
      op_x = 3'bxxx; src_x = 1'bx;
      do begin
        if (state == 3'd3) begin
          op_x = op;
          src_x = ALUSrc;
        end
        nrw += int'(RegWrite);
        nmr += int'(MemRead);
        nmw += int'(MemWrite);
        nm2r += int'(Mem2Reg);
        tick();
        cyc++;
      end while (state != 3'd1 && cyc < 10);
      exp_pc = v[i].taken ? v[i].tgt : exp_pc + 32'd4;
      exp_ret++;
      chk({v[i].name, "_lat"}, cyc,     v[i].lat);
      chk({v[i].name, "_pc"},  PCin,    exp_pc);
      chk({v[i].name, "_ret"}, retired, exp_ret);
      chk({v[i].name, "_rw"},  nrw,     v[i].rw);
      chk({v[i].name, "_mr"},  nmr,     v[i].mr);
      chk({v[i].name, "_mw"},  nmw,     v[i].mw);
      chk({v[i].name, "_m2r"}, nm2r,    v[i].m2r);
      chk({v[i].name, "_op"},  op_x,    v[i].op);
      chk({v[i].name, "_src"}, src_x,   v[i].src);
    end

    ins = 32'h00508193;
    zero = 1'b0;
    tick();
    run = 1'b0;
    tick();
    tick();
    tick();
    exp_pc = exp_pc + 32'd4;
    exp_ret++;
    chk("drop_state", state,   3'd0);
    chk("drop_pc",    PCin,    exp_pc);
    chk("drop_ret",   retired, exp_ret);
    tick();
    chk("drop_hold", state, 3'd0);
    run = 1'b1;
    tick();
    chk("rerun_fetch", state, 3'd1);

    tick();
    run = 1'b0;
    tick();
    tick();
    run = 1'b1;
    tick();
    exp_pc = exp_pc + 32'd4;
    chk("bounce_state", state, 3'd1);
    chk("bounce_pc",    PCin,  exp_pc);

    ins = 32'h002081B3;
    tick();
    tick();
    chk("pre_rst_exec", state, 3'd3);
    #2;
    reset = 1'b1;
    #1;
    chk("async_pc",    PCin,     32'h28);
    chk("async_state", state,    3'd0);
    chk("async_rw",    RegWrite, 0);
    chk("async_ret",   retired,  0);

    run = 1'b1;
    ins = 32'h00508193;
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    chk("lim_fetch", state3, 3'd1);
    repeat (11) tick();
    chk("lim_early_done", done3,    0);
    chk("lim_early_ret",  retired3, 2);
    tick();
    chk("lim_done",  done3,    1);
    chk("lim_state", state3,   3'd0);
    chk("lim_ret",   retired3, 3);
    chk("lim_pc",    PCin3,    32'h34);
    chk("nolim_ret",   retired, 3);
    chk("nolim_state", state,   3'd1);
    repeat (3) tick();
    chk("lim_ignore_run", state3,   3'd0);
    chk("lim_hold_ret",   retired3, 3);

    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    ins = 32'h0000007F;
    tick();
    tick();
    tick();
`ifdef ILLEGAL_TRAP_EN
    chk("ill_state", state,   3'd6);
    chk("ill_err",   err,     1);
    chk("ill_pc",    PCin,    32'h28);
    chk("ill_ret",   retired, 0);
    chk("ill_ctl",   {RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg}, 0);
    repeat (3) tick();
    chk("ill_stuck", state, 3'd6);
`else
    chk("ill_state", state,   3'd1);
    chk("ill_err",   err,     0);
    chk("ill_pc",    PCin,    32'h2C);
    chk("ill_ret",   retired, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
